// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an 8-bit FIFO one byte at a time and serializes each byte
// as a UART frame (start, 8 data bits LSB first, optional even parity, 1-2 stops).
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       empty,
    input  logic [7:0] dout,
    output logic       rd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    // Refuse to elaborate with a baud divider too small for a one-cycle
    // lookahead on frame_done, or with an unsupported stop-bit count.
    if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
        $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2 and STOP_BITS must be 1 or 2");
    end

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BIT_LAST    = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_PRELAST = BW'(CLKS_PER_BIT - 2);
    localparam logic          STOP_LAST   = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic [BW-1:0] bcnt;
    logic [2:0]    bit_idx;
    logic          stop_cnt;
    logic [7:0]    shreg;
    logic          parity;

    // FIFO pop strobe: only from IDLE, never while empty, never during reset.
    assign rd   = rst && (state == IDLE) && en && !empty;
    assign busy = (state != IDLE);

    // Frame sequencer; tx and frame_done are loaded with the value they must
    // carry in the cycle the state register moves into.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bcnt       <= '0;
            bit_idx    <= 3'd0;
            stop_cnt   <= 1'b0;
            shreg      <= 8'h00;
            parity     <= 1'b0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (en && !empty) begin
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    shreg  <= dout;
                    parity <= ^dout;
                    bcnt   <= '0;
                    tx     <= 1'b0;
                    state  <= START;
                end

                START: begin
                    if (bcnt == BIT_LAST) begin
                        bcnt    <= '0;
                        bit_idx <= 3'd0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        bcnt <= bcnt + BW'(1);
                    end
                end

                DATA: begin
                    if (bcnt == BIT_LAST) begin
                        bcnt    <= '0;
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                tx    <= parity;
                                state <= PARITY;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            tx <= shreg[1];
                        end
                    end else begin
                        bcnt <= bcnt + BW'(1);
                    end
                end

                PARITY: begin
                    if (bcnt == BIT_LAST) begin
                        bcnt     <= '0;
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end else begin
                        bcnt <= bcnt + BW'(1);
                    end
                end

                STOP: begin
                    tx <= 1'b1;
                    if (bcnt == BIT_LAST) begin
                        bcnt <= '0;
                        if (stop_cnt == STOP_LAST) begin
                            stop_cnt <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end else begin
                        bcnt <= bcnt + BW'(1);
                        if (stop_cnt == STOP_LAST && bcnt == BIT_PRELAST) begin
                            frame_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two instances (8N1 and 8E2, both 4 clocks per bit) fed by
// behavioural FIFOs; every frame is compared cycle by cycle with a bit-list model.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] en;
    logic [1:0] empty;
    logic [7:0] dout [2];
    logic [1:0] rd;
    logic [1:0] tx;
    logic [1:0] busy;
    logic [1:0] frameDone;

    logic [7:0] mem [2][256];
    int         pushCount [2];
    int         popCount  [2];
    int         expIdx    [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .en(en[0]), .empty(empty[0]), .dout(dout[0]),
        .rd(rd[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(frameDone[0])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .en(en[1]), .empty(empty[1]), .dout(dout[1]),
        .rd(rd[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(frameDone[1])
    );

    assign empty[0] = (pushCount[0] == popCount[0]);
    assign empty[1] = (pushCount[1] == popCount[1]);

    // Behavioural FIFOs: data is valid the cycle after a pop, garbage otherwise.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rd[d] && popCount[d] != pushCount[d]) begin
                dout[d]     <= mem[d][popCount[d] % 256];
                popCount[d] <= popCount[d] + 1;
            end else begin
                dout[d] <= 8'($urandom);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [7:0] b);
        mem[d][pushCount[d] % 256] = b;
        pushCount[d] = pushCount[d] + 1;
    endtask

    function automatic int frameLen(input int d);
        return (d == 0) ? (1 + 8 + 0 + 1) * CPB : (1 + 8 + 1 + 2) * CPB;
    endfunction

    // Expected line level at cycle i of a frame, from the bit list
    // start, d0..d7, [even parity], stop(s).
    function automatic logic expTx(input int d, input logic [7:0] b, input int i);
        int bitNo;
        bitNo = i / CPB;
        if (bitNo == 0) return 1'b0;
        if (bitNo <= 8) return b[bitNo - 1];
        if (d == 1 && bitNo == 9) return ^b;
        return 1'b1;
    endfunction

    // Wait (bounded) for a read strobe; returns inside the rd cycle.
    task automatic waitRd(input int d, input int budget);
        bit found;
        found = 1'b0;
        for (int n = 0; n < budget; n++) begin
            #1;
            if (rd[d]) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) checkOutput("rd_wait", 32'd0, 32'd1);
    endtask

    // Called in the cycle rd is high: checks FETCH, the whole frame and the
    // following IDLE cycle. dropEnAt >= 0 lowers en at that frame cycle.
    task automatic runFrame(input int d, input int dropEnAt);
        logic [7:0] b;
        int         len;
        b   = mem[d][expIdx[d] % 256];
        len = frameLen(d);
        expIdx[d] = expIdx[d] + 1;
        @(negedge clk);
        checkOutput("fetch_tx", 32'(tx[d]), 32'd1);
        checkOutput("fetch_rd", 32'(rd[d]), 32'd0);
        checkOutput("fetch_busy", 32'(busy[d]), 32'd1);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            checkOutput($sformatf("tx_d%0d_b%02h_c%0d", d, b, i), 32'(tx[d]), 32'(expTx(d, b, i)));
            checkOutput("frame_busy", 32'(busy[d]), 32'd1);
            checkOutput("frame_done", 32'(frameDone[d]), 32'(i == len - 1));
            checkOutput("frame_rd", 32'(rd[d]), 32'd0);
            if (i == dropEnAt) en[d] = 1'b0;
        end
        @(negedge clk);
        checkOutput("idle_busy", 32'(busy[d]), 32'd0);
        checkOutput("idle_tx", 32'(tx[d]), 32'd1);
        checkOutput("idle_done", 32'(frameDone[d]), 32'd0);
        checkOutput("idle_rd", 32'(rd[d]), 32'(en[d] && !empty[d]));
    endtask

    initial begin
        logic [7:0] b2b [3];
        b2b[0] = 8'h00;
        b2b[1] = 8'hFF;
        b2b[2] = 8'h3C;
        for (int d = 0; d < 2; d++) begin
            pushCount[d] = 0;
            popCount[d]  = 0;
            expIdx[d]    = 0;
            dout[d]      = 8'h00;
        end
        en = 2'b01;

        // Reset held with data waiting and enable high.
        applyStimulus(0, 8'hA5);
        repeat (8) begin
            @(negedge clk);
            checkOutput("rst_tx", 32'(tx[0]), 32'd1);
            checkOutput("rst_rd", 32'(rd[0]), 32'd0);
            checkOutput("rst_busy", 32'(busy[0]), 32'd0);
            checkOutput("rst_done", 32'(frameDone[0]), 32'd0);
        end
        rst = 1'b1;
        #1 checkOutput("rd_after_release", 32'(rd[0]), 32'd1);
        runFrame(0, -1);

        // Back-to-back frames, then nothing once empty.
        @(negedge clk);
        for (int k = 0; k < 3; k++) applyStimulus(0, b2b[k]);
        waitRd(0, 10);
        for (int k = 0; k < 3; k++) runFrame(0, -1);
        repeat (20) begin
            @(negedge clk);
            checkOutput("no_rd_when_empty", 32'(rd[0]), 32'd0);
        end

        // Random bytes, back to back.
        for (int k = 0; k < 6; k++) applyStimulus(0, 8'($urandom));
        waitRd(0, 10);
        for (int k = 0; k < 6; k++) runFrame(0, -1);

        // Enable low blocks reads; dropping it mid-frame finishes the frame.
        @(negedge clk);
        en[0] = 1'b0;
        applyStimulus(0, 8'h81);
        applyStimulus(0, 8'($urandom));
        repeat (100) begin
            @(negedge clk);
            checkOutput("en_low_rd", 32'(rd[0]), 32'd0);
        end
        en[0] = 1'b1;
        waitRd(0, 5);
        runFrame(0, 12);
        repeat (30) begin
            @(negedge clk);
            checkOutput("en_dropped_rd", 32'(rd[0]), 32'd0);
        end
        en[0] = 1'b1;
        waitRd(0, 5);
        runFrame(0, -1);

        // Parity with two stop bits on the second instance.
        en = 2'b10;
        applyStimulus(1, 8'h07);
        for (int k = 0; k < 3; k++) applyStimulus(1, 8'($urandom));
        waitRd(1, 10);
        for (int k = 0; k < 4; k++) runFrame(1, -1);

        // Reset in the middle of data bit 3 abandons the frame.
        en = 2'b01;
        @(negedge clk);
        applyStimulus(0, 8'h00);
        applyStimulus(0, 8'h5A);
        waitRd(0, 10);
        expIdx[0] = expIdx[0] + 1;
        @(negedge clk);
        repeat (18) @(negedge clk);
        checkOutput("pre_reset_tx", 32'(tx[0]), 32'd0);
        checkOutput("pre_reset_busy", 32'(busy[0]), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_tx", 32'(tx[0]), 32'd1);
        checkOutput("async_rst_rd", 32'(rd[0]), 32'd0);
        checkOutput("async_rst_busy", 32'(busy[0]), 32'd0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_hold_rd", 32'(rd[0]), 32'd0);
            checkOutput("rst_hold_tx", 32'(tx[0]), 32'd1);
        end
        rst = 1'b1;
        #1 checkOutput("rd_after_rerelease", 32'(rd[0]), 32'd1);
        runFrame(0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
